// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: CPU, DMA and RAM signal bundle around the shared-RAM arbiter
interface mem_bus_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [1:0]        grant;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, ram_rdata,
    output cpu_rdata, cpu_ready, dma_rdata, dma_ack, ram_en, ram_we, ram_addr, ram_wdata, grant
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, ram_rdata,
    input  cpu_rdata, cpu_ready, dma_rdata, dma_ack, ram_en, ram_we, ram_addr, ram_wdata, grant
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sequencer sharing one fixed-latency synchronous RAM between CPU and DMA
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input logic clk,
  input logic rst,
  mem_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [1:0] CNT_INIT = RAM_LAT > 1 ? 2'(RAM_LAT - 2) : 2'd0;
  state_t state, state_nx;
  logic owner, last_owner, we_q, pick_dma, any_req, resp_rd;
  logic [1:0] cnt;
  logic [DATA_W-1:0] cpu_hold, dma_hold;
  assign any_req  = bus.cpu_req | bus.dma_req;
  // owner/last_owner: 0 = CPU, 1 = DMA; a tie goes to whoever did not win last
  assign pick_dma = bus.dma_req & (~bus.cpu_req | ~last_owner);
  assign resp_rd  = (state == RESP) & ~we_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= 1'b0;
      last_owner    <= 1'b1;
      we_q          <= 1'b0;
      cnt           <= 2'd0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      cpu_hold      <= '0;
      dma_hold      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        owner         <= pick_dma;
        last_owner    <= pick_dma;
        we_q          <= pick_dma ? bus.dma_we : bus.cpu_we;
        bus.ram_addr  <= pick_dma ? bus.dma_addr : bus.cpu_addr;
        bus.ram_wdata <= pick_dma ? bus.dma_wdata : bus.cpu_wdata;
      end
      if (state == ISSUE) cnt <= CNT_INIT;
      else if (state == WAIT) cnt <= cnt - 2'd1;
      if (resp_rd && !owner) cpu_hold <= bus.ram_rdata;
      if (resp_rd && owner) dma_hold <= bus.ram_rdata;
    end
  end
  always_comb begin
    state_nx = state == IDLE  ? (any_req ? ISSUE : IDLE) :
               state == ISSUE ? ((we_q || RAM_LAT == 1) ? RESP : WAIT) :
               state == WAIT  ? (cnt == 2'd0 ? RESP : WAIT) : IDLE;
  end
  assign bus.ram_en    = state == ISSUE;
  assign bus.ram_we    = (state == ISSUE) & we_q;
  assign bus.grant     = state == IDLE ? 2'b00 : {owner, ~owner};
  assign bus.dma_ack   = (state == RESP) & owner;
  assign bus.cpu_ready = ~bus.cpu_req | ((state == RESP) & ~owner);
  assign bus.cpu_rdata = (resp_rd & ~owner) ? bus.ram_rdata : cpu_hold;
  assign bus.dma_rdata = (resp_rd & owner) ? bus.ram_rdata : dma_hold;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of one RAM_LAT=1 and one RAM_LAT=3 arbiter
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] g_exp [9] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01};
  logic       r_exp [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       a_exp [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();
  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));
  always #5 clk = ~clk;
  task automatic nx;
    @(posedge clk);
    #1;
  endtask
  task automatic ck;
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  initial begin
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = 0; b1.cpu_wdata = 0;
    b1.dma_req = 0; b1.dma_we = 0; b1.dma_addr = 0; b1.dma_wdata = 0; b1.ram_rdata = 32'hBAD0BAD0;
    b3.cpu_req = 0; b3.cpu_we = 0; b3.cpu_addr = 0; b3.cpu_wdata = 0;
    b3.dma_req = 0; b3.dma_we = 0; b3.dma_addr = 0; b3.dma_wdata = 0; b3.ram_rdata = 32'hBAD0BAD0;
    nx; nx;
    rst = 0;
    ck;
    chk("rst_ram_en", b1.ram_en, 1'b0);
    chk("rst_ram_we", b1.ram_we, 1'b0);
    chk("rst_ram_addr", b1.ram_addr, 32'h0);
    chk("rst_ram_wdata", b1.ram_wdata, 32'h0);
    chk("rst_grant", b1.grant, 2'b00);
    chk("rst_cpu_rdata", b1.cpu_rdata, 32'h0);
    chk("rst_dma_rdata", b1.dma_rdata, 32'h0);
    chk("rst_dma_ack", b1.dma_ack, 1'b0);
    chk("rst_cpu_ready", b1.cpu_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      nx; ck;
      chk("idle_ram_en1", b1.ram_en, 1'b0);
      chk("idle_ram_en3", b3.ram_en, 1'b0);
    end
    nx; b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 32'h10; ck;
    chk("rd_c0_ready", b1.cpu_ready, 1'b0);
    chk("rd_c0_ram_en", b1.ram_en, 1'b0);
    chk("rd_c0_grant", b1.grant, 2'b00);
    nx; ck;
    chk("rd_c1_ram_en", b1.ram_en, 1'b1);
    chk("rd_c1_ram_we", b1.ram_we, 1'b0);
    chk("rd_c1_ram_addr", b1.ram_addr, 32'h10);
    chk("rd_c1_ready", b1.cpu_ready, 1'b0);
    chk("rd_c1_grant", b1.grant, 2'b01);
    nx; b1.ram_rdata = 32'hDEADBEEF; ck;
    chk("rd_c2_ready", b1.cpu_ready, 1'b1);
    chk("rd_c2_rdata", b1.cpu_rdata, 32'hDEADBEEF);
    chk("rd_c2_ram_en", b1.ram_en, 1'b0);
    nx; b1.cpu_req = 0; b1.ram_rdata = 32'hBAD0BAD0; ck;
    chk("rd_hold", b1.cpu_rdata, 32'hDEADBEEF);
    chk("rd_c3_grant", b1.grant, 2'b00);
    nx; b1.cpu_req = 1; b1.cpu_we = 1; b1.cpu_addr = 32'h20; b1.cpu_wdata = 32'h12345678; ck;
    chk("wr_c0_ready", b1.cpu_ready, 1'b0);
    nx; ck;
    chk("wr_c1_ram_en", b1.ram_en, 1'b1);
    chk("wr_c1_ram_we", b1.ram_we, 1'b1);
    chk("wr_c1_ram_addr", b1.ram_addr, 32'h20);
    chk("wr_c1_ram_wdata", b1.ram_wdata, 32'h12345678);
    nx; ck;
    chk("wr_c2_ready", b1.cpu_ready, 1'b1);
    chk("wr_c2_rdata_kept", b1.cpu_rdata, 32'hDEADBEEF);
    nx; b1.cpu_req = 0; b1.cpu_we = 0; ck;
    chk("wr_c3_ram_en", b1.ram_en, 1'b0);
    nx; rst = 1;
    nx; rst = 0; ck;
    chk("rst2_cpu_rdata", b1.cpu_rdata, 32'h0);
    nx;
    b1.cpu_req = 1; b1.cpu_we = 1; b1.cpu_addr = 32'h30; b1.cpu_wdata = 32'h1;
    b1.dma_req = 1; b1.dma_we = 1; b1.dma_addr = 32'h50; b1.dma_wdata = 32'h2;
    ck;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin nx; ck; end
      chk("rr_grant", b1.grant, g_exp[i]);
      chk("rr_cpu_ready", b1.cpu_ready, r_exp[i]);
      chk("rr_dma_ack", b1.dma_ack, a_exp[i]);
      if (i == 1) chk("rr_addr_cpu", b1.ram_addr, 32'h30);
      if (i == 4) chk("rr_addr_dma", b1.ram_addr, 32'h50);
      if (i == 4) chk("rr_wdata_dma", b1.ram_wdata, 32'h2);
    end
    nx; b1.cpu_req = 0; b1.dma_req = 0; b1.cpu_we = 0; b1.dma_we = 0; ck;
    chk("rr_end_grant", b1.grant, 2'b00);
    nx; b3.dma_req = 1; b3.dma_we = 0; b3.dma_addr = 32'h40; ck;
    chk("l3_c0_grant", b3.grant, 2'b00);
    nx; ck;
    chk("l3_c1_ram_en", b3.ram_en, 1'b1);
    chk("l3_c1_ram_addr", b3.ram_addr, 32'h40);
    chk("l3_c1_grant", b3.grant, 2'b10);
    nx; ck;
    chk("l3_c2_ram_en", b3.ram_en, 1'b0);
    chk("l3_c2_ack", b3.dma_ack, 1'b0);
    nx; ck;
    chk("l3_c3_ack", b3.dma_ack, 1'b0);
    nx; b3.ram_rdata = 32'hCAFEF00D; ck;
    chk("l3_c4_ack", b3.dma_ack, 1'b1);
    chk("l3_c4_rdata", b3.dma_rdata, 32'hCAFEF00D);
    nx; b3.dma_req = 0; b3.ram_rdata = 32'hBAD0BAD0; ck;
    chk("l3_c5_ack", b3.dma_ack, 1'b0);
    chk("l3_c5_hold", b3.dma_rdata, 32'hCAFEF00D);
    chk("l3_c5_grant", b3.grant, 2'b00);
    nx; ck;
    chk("l3_c6_hold", b3.dma_rdata, 32'hCAFEF00D);
    nx; b3.dma_req = 1; b3.dma_addr = 32'h44; ck;
    nx; ck;
    chk("ra_c1_ram_en", b3.ram_en, 1'b1);
    nx; rst = 1; ck;
    chk("ra_c2_grant", b3.grant, 2'b10);
    nx; rst = 0; b3.dma_req = 0; b3.ram_rdata = 32'h55AA55AA; ck;
    chk("ra_c3_grant", b3.grant, 2'b00);
    chk("ra_c3_ack", b3.dma_ack, 1'b0);
    chk("ra_c3_rdata", b3.dma_rdata, 32'h0);
    chk("ra_c3_ram_en", b3.ram_en, 1'b0);
    for (int i = 0; i < 3; i++) begin
      nx; ck;
      chk("ra_no_ack", b3.dma_ack, 1'b0);
      chk("ra_rdata", b3.dma_rdata, 32'h0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
